// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared constants and helpers for the 5-stage pipeline sequencer.
//   RegAddrBusW            : register address width
//   FWD_RF/EXE/MEM/WB      : 2-bit bypass source selects
//   reg_match()            : RAW match of one ID source against one dest reg
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

   localparam int RegAddrBusW = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EXE = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b11;

   // r0 is hard-wired zero, so it can never carry a dependency.
   function automatic logic reg_match(input logic                   re,
                                      input logic [RegAddrBusW-1:0] rs,
                                      input logic [RegAddrBusW-1:0] dest);
      return re & (rs != {RegAddrBusW{1'b0}}) & (rs == dest);
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
//   Bundle of stage status inputs and control outputs of the pipeline sequencer.
//   slave  : seen by pipe_ctrl (status in, enables/valids/counters out)
//   master : seen by the datapath / bench (drives status, observes controls)
//   Optional macro PIPE_FWD_EN adds the bypass select signals.
// -----------------------------------------------------------------------------
interface pipe_ctrl_if
   import pipe_ctrl_pkg::*;
   #(parameter int PERF_CNT_W = 32);

   logic                   ctl_if_over_i;
   logic                   ctl_exe_over_i;
   logic                   ctl_mem_over_i;
   logic                   ctl_exe_is_load_i;
   logic [RegAddrBusW-1:0] ctl_exe_dest_i;
   logic [RegAddrBusW-1:0] ctl_mem_dest_i;
   logic [RegAddrBusW-1:0] ctl_wb_dest_i;
   logic [RegAddrBusW-1:0] ctl_id_rs1_i;
   logic                   ctl_id_rs1_re_i;
   logic [RegAddrBusW-1:0] ctl_id_rs2_i;
   logic                   ctl_id_rs2_re_i;
   logic                   ctl_br_flush_i;

   logic                   ctl_if_allowin_o;
   logic                   ctl_if_cancel_o;
   logic                   ctl_id_latch_o;
   logic                   ctl_exe_latch_o;
   logic                   ctl_mem_latch_o;
   logic                   ctl_wb_latch_o;
   logic                   ctl_id_valid_o;
   logic                   ctl_exe_valid_o;
   logic                   ctl_mem_valid_o;
   logic                   ctl_wb_valid_o;
`ifdef PIPE_FWD_EN
   logic [1:0]             ctl_fwd_rs1_sel_o;
   logic [1:0]             ctl_fwd_rs2_sel_o;
`endif
   logic [PERF_CNT_W-1:0]  perf_retire_o;
   logic [PERF_CNT_W-1:0]  perf_stall_o;

   modport slave (
      input  ctl_if_over_i, ctl_exe_over_i, ctl_mem_over_i, ctl_exe_is_load_i,
             ctl_exe_dest_i, ctl_mem_dest_i, ctl_wb_dest_i,
             ctl_id_rs1_i, ctl_id_rs1_re_i, ctl_id_rs2_i, ctl_id_rs2_re_i,
             ctl_br_flush_i,
      output ctl_if_allowin_o, ctl_if_cancel_o,
             ctl_id_latch_o, ctl_exe_latch_o, ctl_mem_latch_o, ctl_wb_latch_o,
             ctl_id_valid_o, ctl_exe_valid_o, ctl_mem_valid_o, ctl_wb_valid_o,
             perf_retire_o, perf_stall_o
`ifdef PIPE_FWD_EN
      , output ctl_fwd_rs1_sel_o, ctl_fwd_rs2_sel_o
`endif
   );

   modport master (
      output ctl_if_over_i, ctl_exe_over_i, ctl_mem_over_i, ctl_exe_is_load_i,
             ctl_exe_dest_i, ctl_mem_dest_i, ctl_wb_dest_i,
             ctl_id_rs1_i, ctl_id_rs1_re_i, ctl_id_rs2_i, ctl_id_rs2_re_i,
             ctl_br_flush_i,
      input  ctl_if_allowin_o, ctl_if_cancel_o,
             ctl_id_latch_o, ctl_exe_latch_o, ctl_mem_latch_o, ctl_wb_latch_o,
             ctl_id_valid_o, ctl_exe_valid_o, ctl_mem_valid_o, ctl_wb_valid_o,
             perf_retire_o, perf_stall_o
`ifdef PIPE_FWD_EN
      , input ctl_fwd_rs1_sel_o, ctl_fwd_rs2_sel_o
`endif
   );

endinterface

// File: rtl/pipe_ctrl_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipe_hazard_unit
//   Combinational RAW check of one ID source register against EXE/MEM/WB.
//   re, rs                    : source read enable / address
//   exe/mem/wb_dest           : downstream dest regs (0 when no write)
//   stall                     : ID must hold this cycle
//   With PIPE_FWD_EN also:
//   exe_is_load, exe_over     : EXE producer state
//   fwd_sel                   : bypass source (EXE > MEM > WB > RF)
// -----------------------------------------------------------------------------
module pipe_hazard_unit
   import pipe_ctrl_pkg::*;
(
   input  logic                   re,
   input  logic [RegAddrBusW-1:0] rs,
   input  logic [RegAddrBusW-1:0] exe_dest,
   input  logic [RegAddrBusW-1:0] mem_dest,
   input  logic [RegAddrBusW-1:0] wb_dest,
`ifdef PIPE_FWD_EN
   input  logic                   exe_is_load,
   input  logic                   exe_over,
   output logic [1:0]             fwd_sel,
`endif
   output logic                   stall
);

   logic m_exe;
   logic m_mem;
   logic m_wb;

   assign m_exe = reg_match(re, rs, exe_dest);
   assign m_mem = reg_match(re, rs, mem_dest);
   assign m_wb  = reg_match(re, rs, wb_dest);

`ifdef PIPE_FWD_EN
   // Only an EXE producer without a result yet (load or busy unit) blocks ID.
   assign stall = m_exe & (exe_is_load | ~exe_over);

   // Bypass source select, youngest producer wins.
   always_comb begin
      fwd_sel = FWD_RF;
      if (m_exe) begin
         fwd_sel = FWD_EXE;
      end else if (m_mem) begin
         fwd_sel = FWD_MEM;
      end else if (m_wb) begin
         fwd_sel = FWD_WB;
      end else begin
         fwd_sel = FWD_RF;
      end
   end
`else
   // Without bypass, wait until the producer has left WB.
   assign stall = m_exe | m_mem | m_wb;
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//   Sequencer for the IF/ID/EXE/MEM/WB pipeline: stage valid flags, allowin
//   chain, bus-register latch enables, RAW hazard stall, branch flush and
//   retire/stall performance counters.
//   clk_i  : clock (rising edge)
//   rst_i  : synchronous active-high reset
//   bus    : pipe_ctrl_if.slave (status in, control/valid/counters out)
//   Optional macro PIPE_FWD_EN: bypass selects, stall only on load-use/busy EXE.
// -----------------------------------------------------------------------------
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int PERF_CNT_W = 32
)(
   input  logic       clk_i,
   input  logic       rst_i,
   pipe_ctrl_if.slave bus
);

   logic id_v, exe_v, mem_v, wb_v;
   logic id_over, exe_over, mem_over, wb_over;
   logic id_allowin, exe_allowin, mem_allowin, wb_allowin;
   logic id_latch, exe_latch, mem_latch, wb_latch;
   logic stall_rs1, stall_rs2, hazard, flush;
   logic [PERF_CNT_W-1:0] retire_cnt;
   logic [PERF_CNT_W-1:0] stall_cnt;

   pipe_hazard_unit u_haz_rs1 (
      .re          (bus.ctl_id_rs1_re_i),
      .rs          (bus.ctl_id_rs1_i),
      .exe_dest    (bus.ctl_exe_dest_i),
      .mem_dest    (bus.ctl_mem_dest_i),
      .wb_dest     (bus.ctl_wb_dest_i),
`ifdef PIPE_FWD_EN
      .exe_is_load (bus.ctl_exe_is_load_i),
      .exe_over    (bus.ctl_exe_over_i),
      .fwd_sel     (bus.ctl_fwd_rs1_sel_o),
`endif
      .stall       (stall_rs1)
   );

   pipe_hazard_unit u_haz_rs2 (
      .re          (bus.ctl_id_rs2_re_i),
      .rs          (bus.ctl_id_rs2_i),
      .exe_dest    (bus.ctl_exe_dest_i),
      .mem_dest    (bus.ctl_mem_dest_i),
      .wb_dest     (bus.ctl_wb_dest_i),
`ifdef PIPE_FWD_EN
      .exe_is_load (bus.ctl_exe_is_load_i),
      .exe_over    (bus.ctl_exe_over_i),
      .fwd_sel     (bus.ctl_fwd_rs2_sel_o),
`endif
      .stall       (stall_rs2)
   );

`ifndef PIPE_FWD_EN
   // The load flag only matters for the bypass network.
   logic unused_exe_is_load;
   assign unused_exe_is_load = bus.ctl_exe_is_load_i;
`endif

   assign hazard   = stall_rs1 | stall_rs2;
   assign flush    = bus.ctl_br_flush_i & exe_v;

   assign id_over  = id_v & ~hazard;
   assign exe_over = exe_v & bus.ctl_exe_over_i;
   assign mem_over = mem_v & bus.ctl_mem_over_i;
   assign wb_over  = wb_v;

   // Backpressure ripples from WB toward ID; an empty stage always accepts.
   assign wb_allowin  = 1'b1;
   assign mem_allowin = ~mem_v | (mem_over & wb_allowin);
   assign exe_allowin = ~exe_v | (exe_over & mem_allowin);
   assign id_allowin  = ~id_v  | (id_over  & exe_allowin);

   // A flush kills both the fetch entering ID and the ID op entering EXE.
   assign id_latch  = bus.ctl_if_over_i & id_allowin & ~flush;
   assign exe_latch = id_over  & exe_allowin & ~flush;
   assign mem_latch = exe_over & mem_allowin;
   assign wb_latch  = mem_over & wb_allowin;

   // Stage valid flags: load on allowin, otherwise hold; flush clears ID.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         id_v  <= 1'b0;
         exe_v <= 1'b0;
         mem_v <= 1'b0;
         wb_v  <= 1'b0;
      end else begin
         if (flush) begin
            id_v <= 1'b0;
         end else if (id_allowin) begin
            id_v <= id_latch;
         end else begin
            id_v <= id_v;
         end
         if (exe_allowin) begin
            exe_v <= exe_latch;
         end else begin
            exe_v <= exe_v;
         end
         if (mem_allowin) begin
            mem_v <= mem_latch;
         end else begin
            mem_v <= mem_v;
         end
         wb_v <= wb_latch;
      end
   end

   // Retire and hazard-stall counters, wrapping naturally at full width.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         retire_cnt <= {PERF_CNT_W{1'b0}};
         stall_cnt  <= {PERF_CNT_W{1'b0}};
      end else begin
         if (wb_over) begin
            retire_cnt <= retire_cnt + {{(PERF_CNT_W-1){1'b0}}, 1'b1};
         end else begin
            retire_cnt <= retire_cnt;
         end
         if (id_v & hazard) begin
            stall_cnt <= stall_cnt + {{(PERF_CNT_W-1){1'b0}}, 1'b1};
         end else begin
            stall_cnt <= stall_cnt;
         end
      end
   end

   assign bus.ctl_if_allowin_o = id_allowin & ~flush;
   assign bus.ctl_if_cancel_o  = flush;
   assign bus.ctl_id_latch_o   = id_latch;
   assign bus.ctl_exe_latch_o  = exe_latch;
   assign bus.ctl_mem_latch_o  = mem_latch;
   assign bus.ctl_wb_latch_o   = wb_latch;
   assign bus.ctl_id_valid_o   = id_v;
   assign bus.ctl_exe_valid_o  = exe_v;
   assign bus.ctl_mem_valid_o  = mem_v;
   assign bus.ctl_wb_valid_o   = wb_v;
   assign bus.perf_retire_o    = retire_cnt;
   assign bus.perf_stall_o     = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
//   Directed test of pipe_ctrl: fill, RAW stall, r0/re qualification, bypass
//   selects (PIPE_FWD_EN builds), EXE busy bubble, branch flush, mid-run reset.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   pipe_ctrl_if #(.PERF_CNT_W(32)) bus ();

   pipe_ctrl #(.PERF_CNT_W(32)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_deps();
      bus.ctl_exe_dest_i    = 5'd0;
      bus.ctl_mem_dest_i    = 5'd0;
      bus.ctl_wb_dest_i     = 5'd0;
      bus.ctl_id_rs1_i      = 5'd0;
      bus.ctl_id_rs1_re_i   = 1'b0;
      bus.ctl_id_rs2_i      = 5'd0;
      bus.ctl_id_rs2_re_i   = 1'b0;
      bus.ctl_exe_is_load_i = 1'b0;
   endtask

   initial begin
      bus.ctl_if_over_i  = 1'b0;
      bus.ctl_exe_over_i = 1'b1;
      bus.ctl_mem_over_i = 1'b1;
      bus.ctl_br_flush_i = 1'b0;
      clear_deps();

      // ---- reset ----
      repeat (3) tick();
      chk("rst_id_v",   32'(bus.ctl_id_valid_o),  32'd0);
      chk("rst_exe_v",  32'(bus.ctl_exe_valid_o), 32'd0);
      chk("rst_mem_v",  32'(bus.ctl_mem_valid_o), 32'd0);
      chk("rst_wb_v",   32'(bus.ctl_wb_valid_o),  32'd0);
      chk("rst_retire", bus.perf_retire_o,         32'd0);
      chk("rst_stall",  bus.perf_stall_o,          32'd0);
      chk("rst_if_allowin", 32'(bus.ctl_if_allowin_o), 32'd1);
      chk("rst_if_cancel",  32'(bus.ctl_if_cancel_o),  32'd0);

      // ---- fill ----
      rst = 1'b0;
      bus.ctl_if_over_i = 1'b1;
      #1;
      chk("fill_id_latch", 32'(bus.ctl_id_latch_o), 32'd1);
      tick();
      chk("fill1_id_v",  32'(bus.ctl_id_valid_o),  32'd1);
      chk("fill1_exe_v", 32'(bus.ctl_exe_valid_o), 32'd0);
      chk("fill1_exe_latch", 32'(bus.ctl_exe_latch_o), 32'd1);
      tick();
      chk("fill2_exe_v", 32'(bus.ctl_exe_valid_o), 32'd1);
      chk("fill2_mem_v", 32'(bus.ctl_mem_valid_o), 32'd0);
      tick();
      chk("fill3_mem_v", 32'(bus.ctl_mem_valid_o), 32'd1);
      chk("fill3_wb_v",  32'(bus.ctl_wb_valid_o),  32'd0);
      tick();
      chk("fill4_wb_v",   32'(bus.ctl_wb_valid_o), 32'd1);
      chk("fill4_retire", bus.perf_retire_o,        32'd0);
      tick();
      chk("fill5_retire", bus.perf_retire_o,        32'd1);
      tick();
      chk("fill6_retire", bus.perf_retire_o,        32'd2);

      // ---- combinational hazard probes (cleared before the next edge) ----
      bus.ctl_id_rs1_i = 5'd0; bus.ctl_id_rs1_re_i = 1'b1; bus.ctl_exe_dest_i = 5'd0;
      #1;
      chk("r0_no_stall", 32'(bus.ctl_if_allowin_o), 32'd1);
`ifdef PIPE_FWD_EN
      chk("r0_fwd_rf", 32'(bus.ctl_fwd_rs1_sel_o), 32'(FWD_RF));
`endif
      bus.ctl_id_rs1_i = 5'd7; bus.ctl_id_rs1_re_i = 1'b0; bus.ctl_exe_dest_i = 5'd7;
      #1;
      chk("re0_no_stall", 32'(bus.ctl_if_allowin_o), 32'd1);
      clear_deps();
      bus.ctl_id_rs2_i = 5'd9; bus.ctl_id_rs2_re_i = 1'b1; bus.ctl_wb_dest_i = 5'd9;
      #1;
`ifdef PIPE_FWD_EN
      chk("rs2_wb_allowin", 32'(bus.ctl_if_allowin_o), 32'd1);
      chk("rs2_fwd_wb", 32'(bus.ctl_fwd_rs2_sel_o), 32'(FWD_WB));
      bus.ctl_mem_dest_i = 5'd9;
      #1;
      chk("rs2_fwd_mem", 32'(bus.ctl_fwd_rs2_sel_o), 32'(FWD_MEM));
      bus.ctl_exe_dest_i = 5'd9;
      #1;
      chk("rs2_fwd_exe", 32'(bus.ctl_fwd_rs2_sel_o), 32'(FWD_EXE));
      chk("rs2_exe_allowin", 32'(bus.ctl_if_allowin_o), 32'd1);
      bus.ctl_exe_is_load_i = 1'b1;
      #1;
      chk("rs2_load_stall", 32'(bus.ctl_if_allowin_o), 32'd0);
`else
      chk("rs2_wb_stall", 32'(bus.ctl_if_allowin_o), 32'd0);
      bus.ctl_wb_dest_i = 5'd0; bus.ctl_mem_dest_i = 5'd9;
      #1;
      chk("rs2_mem_stall", 32'(bus.ctl_if_allowin_o), 32'd0);
`endif
      clear_deps();

      // ---- clocked RAW stall ----
`ifdef PIPE_FWD_EN
      bus.ctl_id_rs1_i = 5'd5; bus.ctl_id_rs1_re_i = 1'b1; bus.ctl_exe_dest_i = 5'd5;
      #1;
      chk("fwd_alu_allowin", 32'(bus.ctl_if_allowin_o), 32'd1);
      chk("fwd_alu_sel", 32'(bus.ctl_fwd_rs1_sel_o), 32'(FWD_EXE));
      bus.ctl_exe_is_load_i = 1'b1;
      #1;
      chk("fwd_load_allowin", 32'(bus.ctl_if_allowin_o), 32'd0);
      tick();
      chk("fwd_load_stall_cnt", bus.perf_stall_o, 32'd1);
      chk("fwd_load_id_v",  32'(bus.ctl_id_valid_o),  32'd1);
      chk("fwd_load_exe_v", 32'(bus.ctl_exe_valid_o), 32'd0);
      bus.ctl_exe_is_load_i = 1'b0; bus.ctl_exe_dest_i = 5'd0; bus.ctl_mem_dest_i = 5'd5;
      #1;
      chk("fwd_mem_sel", 32'(bus.ctl_fwd_rs1_sel_o), 32'(FWD_MEM));
      chk("fwd_mem_allowin", 32'(bus.ctl_if_allowin_o), 32'd1);
      tick();
      chk("fwd_resume_exe_v", 32'(bus.ctl_exe_valid_o), 32'd1);
      chk("fwd_stall_cnt", bus.perf_stall_o, 32'd1);
`else
      bus.ctl_id_rs1_i = 5'd5; bus.ctl_id_rs1_re_i = 1'b1; bus.ctl_exe_dest_i = 5'd5;
      #1;
      chk("raw_allowin",   32'(bus.ctl_if_allowin_o), 32'd0);
      chk("raw_id_latch",  32'(bus.ctl_id_latch_o),   32'd0);
      chk("raw_exe_latch", 32'(bus.ctl_exe_latch_o),  32'd0);
      tick();
      chk("raw1_id_v",  32'(bus.ctl_id_valid_o),  32'd1);
      chk("raw1_exe_v", 32'(bus.ctl_exe_valid_o), 32'd0);
      chk("raw1_stall", bus.perf_stall_o,          32'd1);
      bus.ctl_exe_dest_i = 5'd0; bus.ctl_mem_dest_i = 5'd5;
      tick();
      chk("raw2_stall", bus.perf_stall_o, 32'd2);
      bus.ctl_mem_dest_i = 5'd0; bus.ctl_wb_dest_i = 5'd5;
      tick();
      chk("raw3_stall", bus.perf_stall_o, 32'd3);
      bus.ctl_wb_dest_i = 5'd0;
      #1;
      chk("raw_release_allowin", 32'(bus.ctl_if_allowin_o), 32'd1);
      chk("raw_release_latch",   32'(bus.ctl_exe_latch_o),  32'd1);
      tick();
      chk("raw_resume_exe_v", 32'(bus.ctl_exe_valid_o), 32'd1);
      chk("raw_final_stall",  bus.perf_stall_o,          32'd3);
`endif
      clear_deps();
      repeat (2) tick();
      chk("refill_mem_v", 32'(bus.ctl_mem_valid_o), 32'd1);
      chk("refill_wb_v",  32'(bus.ctl_wb_valid_o),  32'd1);

      // ---- EXE busy for 4 cycles ----
      bus.ctl_exe_over_i = 1'b0;
      #1;
      chk("busy_allowin",   32'(bus.ctl_if_allowin_o), 32'd0);
      chk("busy_mem_latch", 32'(bus.ctl_mem_latch_o),  32'd0);
      chk("busy_exe_latch", 32'(bus.ctl_exe_latch_o),  32'd0);
      tick();
      chk("busy1_mem_v", 32'(bus.ctl_mem_valid_o), 32'd0);
      chk("busy1_wb_v",  32'(bus.ctl_wb_valid_o),  32'd1);
      tick();
      chk("busy2_wb_v",  32'(bus.ctl_wb_valid_o),  32'd0);
      repeat (2) tick();
      chk("busy4_exe_v",   32'(bus.ctl_exe_valid_o),  32'd1);
      chk("busy4_id_v",    32'(bus.ctl_id_valid_o),   32'd1);
      chk("busy4_allowin", 32'(bus.ctl_if_allowin_o), 32'd0);
      bus.ctl_exe_over_i = 1'b1;
      #1;
      chk("unbusy_allowin", 32'(bus.ctl_if_allowin_o), 32'd1);
      tick();
      chk("unbusy_mem_v", 32'(bus.ctl_mem_valid_o), 32'd1);
      tick();
      chk("unbusy_wb_v",  32'(bus.ctl_wb_valid_o),  32'd1);

      // ---- branch flush ----
      bus.ctl_br_flush_i = 1'b1;
      #1;
      chk("flush_cancel",    32'(bus.ctl_if_cancel_o),  32'd1);
      chk("flush_allowin",   32'(bus.ctl_if_allowin_o), 32'd0);
      chk("flush_id_latch",  32'(bus.ctl_id_latch_o),   32'd0);
      chk("flush_exe_latch", 32'(bus.ctl_exe_latch_o),  32'd0);
      chk("flush_mem_latch", 32'(bus.ctl_mem_latch_o),  32'd1);
      tick();
      chk("flush1_id_v",  32'(bus.ctl_id_valid_o),  32'd0);
      chk("flush1_exe_v", 32'(bus.ctl_exe_valid_o), 32'd0);
      chk("flush1_mem_v", 32'(bus.ctl_mem_valid_o), 32'd1);
      chk("flush_noexe_cancel", 32'(bus.ctl_if_cancel_o), 32'd0);
      bus.ctl_br_flush_i = 1'b0;
      tick();
      chk("flush2_id_v",  32'(bus.ctl_id_valid_o),  32'd1);
      chk("flush2_exe_v", 32'(bus.ctl_exe_valid_o), 32'd0);
      tick();
      chk("flush3_exe_v", 32'(bus.ctl_exe_valid_o), 32'd1);

      // ---- reset mid-operation ----
      repeat (2) tick();
      rst = 1'b1;
      tick();
      chk("mrst_id_v",   32'(bus.ctl_id_valid_o),  32'd0);
      chk("mrst_exe_v",  32'(bus.ctl_exe_valid_o), 32'd0);
      chk("mrst_mem_v",  32'(bus.ctl_mem_valid_o), 32'd0);
      chk("mrst_wb_v",   32'(bus.ctl_wb_valid_o),  32'd0);
      chk("mrst_retire", bus.perf_retire_o,         32'd0);
      chk("mrst_stall",  bus.perf_stall_o,          32'd0);
      rst = 1'b0;
      tick();
      chk("mrst_refill_id_v", 32'(bus.ctl_id_valid_o), 32'd1);
      chk("mrst_retire_hold", bus.perf_retire_o,        32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
